gpr_wb_arbiter: RTL and testbench
=================================

Name: gpr_wb_arbiter

Overview:
- Write-back arbiter in front of the single-write-port GPR file.
- Accepts up to three write requests per cycle:
  - main ALU/load result;
  - link write (jal/bgezal return address to r31);
  - flag write (r30 set/clear).
- Issues exactly one registered write per cycle to the GPR.
- Buffers the remainder in an in-order pending queue, so no competing write is lost and the write order is deterministic.

Parameters:
- DEPTH, 8, pending-queue entries; must be >= 4.
- LINK_REG, 31, destination address of link writes.
- FLAG_REG, 30, destination address of flag writes.

Ports:
- clk  input  1  system clock, all state on posedge.
- reset  input  1  synchronous active-high reset.
- main_we  input  1  main write request.
- main_waddr  input  5  main write address.
- main_wdata  input  32  main write data.
- link_we  input  1  link write request.
- link_data  input  32  link value (PC+8).
- flag_we  input  1  flag write request.
- flag_val  input  1  flag value; zero-extended to 32 bits.
- stall  output  1  arbiter cannot accept new requests this cycle.
- gpr_we  output  1  registered write enable to GPR.
- gpr_waddr  output  5  registered write address.
- gpr_wdata  output  32  registered write data.
- pend_cnt  output  4  occupied queue entries.
- rd_addr_a  input  5  forwarding lookup address A (used only with the optional feature).
- rd_addr_b  input  5  forwarding lookup address B (used only with the optional feature).
- fwd_hit_a  output  1  hit flag for lookup A (optional feature).
- fwd_data_a  output  32  forwarded data for lookup A (optional feature).
- fwd_hit_b  output  1  hit flag for lookup B (optional feature).
- fwd_data_b  output  32  forwarded data for lookup B (optional feature).

Behaviour:
- Reset (sync, any cycle, including mid-drain):
  - Queue flushed; pend_cnt=0.
  - gpr_we=0, gpr_waddr=0, gpr_wdata=0.
  - Pending writes are discarded, not issued.
  - stall=0 on the cycle after reset deasserts.
- Accepted requests:
  - Valid requests: main_we with main_waddr!=0; link_we; flag_we.
  - Requests with main_waddr=0 are discarded silently.
  - Fixed intra-cycle order: link, then main, then flag.
- stall:
  - stall = (DEPTH - pend_cnt) < 3, combinational from registered count.
  - All requests presented while stall=1 are ignored; upstream must hold them.
- Issue selection, at cycle N when not stalled:
  - Queue non-empty: head entry issues; all valid new requests enqueue in intra-cycle order behind the tail.
  - Queue empty: first valid new request issues directly; remaining valid requests enqueue in order.
  - Nothing valid and queue empty: gpr_we=0 next cycle; gpr_waddr and gpr_wdata hold their last value.
  - While stall=1, the head still issues (drain continues).
- Latency:
  - Issued write is registered: appears on gpr_* at cycle N+1 with gpr_we=1 for exactly one cycle.
  - A direct issue therefore has 1-cycle latency.
  - A queued entry has latency 1 + its queue position.
- Queue:
  - Circular buffer with wrap-around of head and tail pointers modulo DEPTH.
  - Simultaneous dequeue of 1 and enqueue of k: pend_cnt' = pend_cnt - 1 + k.
  - pend_cnt never exceeds DEPTH; overflow is impossible by the stall rule.
- Same-address writes:
  - Order preserved, so the later entry wins in the GPR.
  - Example: link and main both targeting r31 means main overwrites link.
- Flag data: gpr_wdata = {31'b0, flag_val}.
- Link address: gpr_waddr = LINK_REG for link writes.

Optional Feature:
- Macro: GPR_WB_FWD_EN.
- Defined:
  - fwd_hit_x=1 when rd_addr_x!=0 and matches any queued entry, or an entry issuing in the current cycle's gpr_* output with gpr_we=1.
  - fwd_data_x = data of the youngest matching entry (queued entries younger than the issued one).
  - Combinational lookup.
- Undefined:
  - fwd_hit_a, fwd_hit_b, fwd_data_a, fwd_data_b tied to 0.
  - rd_addr_a and rd_addr_b unused.

Test Plan:
- Reset during drain:
  - Stimulus: queue 3 entries, assert reset for 1 cycle.
  - Response: pend_cnt=0, gpr_we=0 the next cycle, no further writes.
- Triple request:
  - Stimulus: link_data=0x00400010, main r5=0x1234, flag_val=1, all in one cycle, queue empty.
  - Response: cycles N+1..N+3 give r31=0x00400010, then r5=0x1234, then r30=0x1.
- r0 discard:
  - Stimulus: main_waddr=0, main_wdata=0xDEAD.
  - Response: gpr_we stays 0; pend_cnt unchanged.
- Stall:
  - Stimulus: DEPTH=8; fire three requests per cycle until stall=1 (pend_cnt>=6).
  - Response: further requests ignored; drain continues; stall drops once pend_cnt<=5.
  - Response: total issued writes equal total accepted writes.
- Same address:
  - Stimulus: main r31=0xAAAA plus link 0xBBBB in the same cycle.
  - Response: final issued r31 value is 0xAAAA.
- Forwarding, with GPR_WB_FWD_EN:
  - Stimulus: queue r5=0x11 then r5=0x22; set rd_addr_a=5.
  - Response: fwd_hit_a=1, fwd_data_a=0x22.
  - Response: after both entries have drained, fwd_hit_a=0.

Source files
------------

// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter: write-back arbiter for the single-write-port GPR file.
// Takes up to three write requests per cycle: link (r31), main ALU/load,
// and flag (r30). It issues one registered write per cycle and keeps the
// rest in an in-order circular pending queue. Same-cycle requests are taken
// in the order link, main, flag.
// Optional feature macro: GPR_WB_FWD_EN. When it is defined, the block
// does a combinational forwarding lookup over the issued and queued writes.
module gpr_wb_arbiter #(
    parameter int DEPTH    = 8,
    parameter int LINK_REG = 31,
    parameter int FLAG_REG = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        main_we,
    input  logic [4:0]  main_waddr,
    input  logic [31:0] main_wdata,
    input  logic        link_we,
    input  logic [31:0] link_data,
    input  logic        flag_we,
    input  logic        flag_val,
    output logic        stall,
    output logic        gpr_we,
    output logic [4:0]  gpr_waddr,
    output logic [31:0] gpr_wdata,
    output logic [3:0]  pend_cnt,
    input  logic [4:0]  rd_addr_a,
    input  logic [4:0]  rd_addr_b,
    output logic        fwd_hit_a,
    output logic [31:0] fwd_data_a,
    output logic        fwd_hit_b,
    output logic [31:0] fwd_data_b
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [4:0]    qAddr [DEPTH];
    logic [31:0]   qData [DEPTH];
    logic [PW-1:0] head, tail;
    logic [3:0]    cnt;

    // New requests compacted in priority order; enqueue view skips a direct issue
    logic [4:0]  nAddr [3];
    logic [31:0] nData [3];
    logic [1:0]  nCnt;
    logic [4:0]  eAddr [3];
    logic [31:0] eData [3];
    logic [1:0]  enqN;
    logic        doIssue, doDeq;
    logic [4:0]  issAddr;
    logic [31:0] issData;

    // Modulo-DEPTH pointer advance; n never exceeds DEPTH-1 plus the pointer
    function automatic logic [PW-1:0] ptrAdd(input logic [PW-1:0] p, input int n);
        int s;
        s = int'(p) + n;
        if (s >= DEPTH) s = s - DEPTH;
        return PW'(s);
    endfunction

    // A full triple must always fit, so stall once fewer than 3 slots remain
    assign stall    = int'(cnt) > (DEPTH - 3);
    assign pend_cnt = cnt;

    // Collect valid new requests (ignored while stalled), link/main/flag order
    always_comb begin
        nCnt = '0;
        for (int i = 0; i < 3; i++) begin
            nAddr[i] = '0;
            nData[i] = '0;
        end
        if (!stall) begin
            if (link_we) begin
                nAddr[nCnt] = 5'(LINK_REG);
                nData[nCnt] = link_data;
                nCnt        = nCnt + 2'd1;
            end
            if (main_we && main_waddr != 5'd0) begin
                nAddr[nCnt] = main_waddr;
                nData[nCnt] = main_wdata;
                nCnt        = nCnt + 2'd1;
            end
            if (flag_we) begin
                nAddr[nCnt] = 5'(FLAG_REG);
                nData[nCnt] = {31'b0, flag_val};
                nCnt        = nCnt + 2'd1;
            end
        end
    end

    // Choose the issuing write: queue head first, otherwise the first new request
    always_comb begin
        doDeq   = cnt != 4'd0;
        doIssue = doDeq || (nCnt != 2'd0);
        issAddr = doDeq ? qAddr[head] : nAddr[0];
        issData = doDeq ? qData[head] : nData[0];
        for (int i = 0; i < 3; i++) begin
            eAddr[i] = nAddr[i];
            eData[i] = nData[i];
        end
        enqN = nCnt;
        if (!doDeq && nCnt != 2'd0) begin
            eAddr[0] = nAddr[1]; eData[0] = nData[1];
            eAddr[1] = nAddr[2]; eData[1] = nData[2];
            eAddr[2] = '0;       eData[2] = '0;
            enqN     = nCnt - 2'd1;
        end
    end

    // Pointers, occupancy and the registered GPR write port
    always_ff @(posedge clk) begin
        if (reset) begin
            head      <= '0;
            tail      <= '0;
            cnt       <= '0;
            gpr_we    <= 1'b0;
            gpr_waddr <= '0;
            gpr_wdata <= '0;
        end else begin
            gpr_we <= doIssue;
            if (doIssue) begin
                gpr_waddr <= issAddr;
                gpr_wdata <= issData;
            end
            if (doDeq) head <= ptrAdd(head, 1);
            tail <= ptrAdd(tail, int'(enqN));
            cnt  <= cnt - {3'b0, doDeq} + {2'b0, enqN};
        end
    end

    // Queue storage; contents are don't-care until written so no reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!reset && i < int'(enqN)) begin
                qAddr[ptrAdd(tail, i)] <= eAddr[i];
                qData[ptrAdd(tail, i)] <= eData[i];
            end
        end
    end

`ifdef GPR_WB_FWD_EN
    // Youngest match wins: start from the issued write, then walk head to tail
    always_comb begin
        logic [PW-1:0] idx;
        idx        = '0;
        fwd_hit_a  = gpr_we && rd_addr_a != 5'd0 && gpr_waddr == rd_addr_a;
        fwd_data_a = fwd_hit_a ? gpr_wdata : 32'd0;
        fwd_hit_b  = gpr_we && rd_addr_b != 5'd0 && gpr_waddr == rd_addr_b;
        fwd_data_b = fwd_hit_b ? gpr_wdata : 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = ptrAdd(head, i);
            if (i < int'(cnt)) begin
                if (rd_addr_a != 5'd0 && qAddr[idx] == rd_addr_a) begin
                    fwd_hit_a  = 1'b1;
                    fwd_data_a = qData[idx];
                end
                if (rd_addr_b != 5'd0 && qAddr[idx] == rd_addr_b) begin
                    fwd_hit_b  = 1'b1;
                    fwd_data_b = qData[idx];
                end
            end
        end
    end
`else
    logic unusedRd;
    assign unusedRd   = ^{rd_addr_a, rd_addr_b};
    assign fwd_hit_a  = 1'b0;
    assign fwd_data_a = 32'd0;
    assign fwd_hit_b  = 1'b0;
    assign fwd_data_b = 32'd0;
`endif

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Self-checking bench for gpr_wb_arbiter. Directed scenarios come first,
// followed by randomized traffic, all checked against a queue-based model.
module tb_gpr_wb_arbiter;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        main_we = 1'b0, link_we = 1'b0, flag_we = 1'b0, flag_val = 1'b0;
    logic [4:0]  main_waddr = '0, rd_addr_a = '0, rd_addr_b = '0;
    logic [31:0] main_wdata = '0, link_data = '0;
    logic        stall, gpr_we, fwd_hit_a, fwd_hit_b;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata, fwd_data_a, fwd_data_b;
    logic [3:0]  pend_cnt;

    gpr_wb_arbiter #(.DEPTH(DEPTH), .LINK_REG(31), .FLAG_REG(30)) dut (
        .clk(clk), .reset(reset),
        .main_we(main_we), .main_waddr(main_waddr), .main_wdata(main_wdata),
        .link_we(link_we), .link_data(link_data),
        .flag_we(flag_we), .flag_val(flag_val),
        .stall(stall), .gpr_we(gpr_we), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
        .pend_cnt(pend_cnt), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .fwd_hit_a(fwd_hit_a), .fwd_data_a(fwd_data_a),
        .fwd_hit_b(fwd_hit_b), .fwd_data_b(fwd_data_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    // Model: every pending write in program order, plus the last issued write
    ent_t        q[$];
    logic        mWe = 1'b0;
    logic [4:0]  mA = '0;
    logic [31:0] mD = '0;
    int checks = 0, errors = 0, accepted = 0, issued = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fwdCheck(input string tag, input logic [4:0] rd,
                            input logic hit, input logic [31:0] data);
        logic        eh;
        logic [31:0] ed;
        eh = 1'b0;
        ed = '0;
        if (rd != 5'd0) begin
            if (mWe && mA == rd) begin eh = 1'b1; ed = mD; end
            foreach (q[i]) if (q[i].a == rd) begin eh = 1'b1; ed = q[i].d; end
        end
`ifndef GPR_WB_FWD_EN
        eh = 1'b0;
        ed = '0;
`endif
        check({tag, "_hit"}, {31'b0, hit}, {31'b0, eh});
        check({tag, "_data"}, data, ed);
    endtask

    // One clock: drive requests, check stall/forwarding, then check the issued write
    task automatic step(input logic lw, input logic [31:0] ld, input logic mw,
                        input logic [4:0] ma, input logic [31:0] md,
                        input logic fw, input logic fv);
        bit st;
        ent_t e;
        link_we = lw; link_data = ld;
        main_we = mw; main_waddr = ma; main_wdata = md;
        flag_we = fw; flag_val = fv;
        @(negedge clk);
        st = (DEPTH - q.size()) < 3;
        check("stall", {31'b0, stall}, {31'b0, st});
        fwdCheck("fwd_a", rd_addr_a, fwd_hit_a, fwd_data_a);
        fwdCheck("fwd_b", rd_addr_b, fwd_hit_b, fwd_data_b);
        @(posedge clk);
        #1;
        if (!st) begin
            if (lw) begin q.push_back({5'd31, ld}); accepted++; end
            if (mw && ma != 5'd0) begin q.push_back({ma, md}); accepted++; end
            if (fw) begin q.push_back({5'd30, {31'b0, fv}}); accepted++; end
        end
        if (q.size() > 0) begin
            e = q.pop_front();
            mWe = 1'b1; mA = e.a; mD = e.d;
        end else begin
            mWe = 1'b0;
        end
        if (gpr_we === 1'b1) issued++;
        check("gpr_we", {31'b0, gpr_we}, {31'b0, mWe});
        check("gpr_waddr", {27'b0, gpr_waddr}, {27'b0, mA});
        check("gpr_wdata", gpr_wdata, mD);
        check("pend_cnt", {28'b0, pend_cnt}, 32'(q.size()));
    endtask

    task automatic idle();
        step(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        link_we = 1'b0; main_we = 1'b0; flag_we = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        mWe = 1'b0; mA = '0; mD = '0;
        accepted = 0; issued = 0;
        check("rst_gpr_we", {31'b0, gpr_we}, 32'd0);
        check("rst_gpr_waddr", {27'b0, gpr_waddr}, 32'd0);
        check("rst_gpr_wdata", gpr_wdata, 32'd0);
        check("rst_pend_cnt", {28'b0, pend_cnt}, 32'd0);
        check("rst_stall", {31'b0, stall}, 32'd0);
    endtask

    initial begin
        rd_addr_a = 5'd5;
        rd_addr_b = 5'd31;
        doReset();

        // Triple request into an empty queue: r31, r5, r30 on consecutive cycles
        step(1'b1, 32'h0040_0010, 1'b1, 5'd5, 32'h1234, 1'b1, 1'b1);
        idle();
        idle();
        idle();

        // Writes to r0 are dropped
        step(1'b0, 32'd0, 1'b1, 5'd0, 32'hDEAD, 1'b0, 1'b0);
        idle();

        // Link and main both to r31: main issues last
        step(1'b1, 32'hBBBB, 1'b1, 5'd31, 32'hAAAA, 1'b0, 1'b0);
        idle();
        idle();

        // Two r5 writes queued behind a link; forwarding should return the younger one
        step(1'b1, 32'h100, 1'b1, 5'd5, 32'h11, 1'b0, 1'b0);
        step(1'b1, 32'h104, 1'b1, 5'd5, 32'h22, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) idle();

        // Fill to stall, keep firing while stalled, then drain
        for (int i = 0; i < 6; i++)
            step(1'b1, 32'h200 + i, 1'b1, 5'(i + 1), 32'h300 + i, 1'b1, i[0]);
        for (int i = 0; i < 10; i++) idle();
        check("acc_vs_iss_stall", 32'(issued), 32'(accepted));

        // Reset while entries are still pending; nothing more may issue
        step(1'b1, 32'h400, 1'b1, 5'd7, 32'h401, 1'b1, 1'b0);
        step(1'b1, 32'h402, 1'b1, 5'd8, 32'h403, 1'b1, 1'b1);
        doReset();
        idle();
        idle();
        idle();

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            rd_addr_a = 5'($urandom_range(0, 31));
            rd_addr_b = ($urandom_range(0, 1) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 59) == 0) doReset();
            step(1'($urandom), $urandom, 1'($urandom),
                 ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31)),
                 $urandom, 1'($urandom), 1'($urandom));
        end
        for (int i = 0; i < 12; i++) idle();
        check("acc_vs_iss_rand", 32'(issued), 32'(accepted));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
